rx_sample_buffer: RTL
=====================

# rx_sample_buffer

Parametrised multi-channel receive sample buffer for the Wi-Fi PHY RX path. It sits between the ADC/front-end sample stream and the RX baseband chain. It stores CH parallel DATA-bit samples per word in a circular RAM of 2**AD words and withholds reads until a programmable start level is reached. It also reports fill level and full/empty status, and flags overflow and underrun.

## Interface
- AD, 4: address width; depth DEPTH = 2**AD words
- DATA, 12: bits per channel sample
- CH, 2: channels per word (e.g. I/Q); word width W = CH*DATA
- START_LVL, 8: fill level (1..DEPTH) at which streaming is armed
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of pointers/level/state/flags
- we  in  1  write strobe; data_in captured when accepted
- data_in  in  W  packed sample word, channel 0 in LSBs
- rd_en  in  1  read request
- data_out  out  W  registered read word
- valid_out  out  1  data_out valid this cycle
- level  out  AD+1  current word count 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- streaming  out  1  FSM in STREAM
- overflow  out  1  write dropped (see Configuration)
- underrun  out  1  one-cycle pulse, read requested while empty in STREAM

## Operation
- Pointers wr_ptr and rd_ptr are AD bits wide. They wrap naturally from DEPTH-1 to 0. level is tracked separately, so full and empty are never ambiguous.
- Write accepted: we && !full && !flush. The word is stored at wr_ptr and wr_ptr increments.
- Write while full: the word is dropped, pointers are unchanged, and the overflow event fires. This applies even if a read is accepted in the same cycle, because full is evaluated on the pre-edge level.
- Read accepted: rd_en && streaming && !empty && !flush. The RAM is read at rd_ptr and rd_ptr increments.
- rd_en while empty or while in FILL is ignored; no pointer change.
- level update: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
- The FSM has two states, FILL and STREAM:
  - Reset/flush sends the FSM to FILL.
  - FILL moves to STREAM when level >= START_LVL, evaluated on the registered level.
  - STREAM moves to FILL when rd_en && empty. The same cycle pulses underrun.
  - STREAM is otherwise held, even if level drops below START_LVL.
- flush has priority over we and rd_en. It zeroes the pointers and level, sends the FSM to FILL, forces valid_out to 0, and clears overflow. RAM contents are not cleared.

## Timing
- Reset values: data_out=0, valid_out=0, level=0, full=0, empty=1, streaming=0, overflow=0, underrun=0.
- Read latency is 1 cycle. For a read accepted at edge N, data_out and valid_out=1 are presented after edge N+1. valid_out is 0 in any cycle following a non-accepted read. data_out holds its last value when valid_out=0.
- level, full, empty and streaming are registered. They reflect all writes and reads accepted at the previous edge.
- Write-to-read latency: the first write at edge 0 gives level=1 after edge 1. With START_LVL=1, streaming=1 after edge 2.
- The earliest valid_out after reset is START_LVL+2 edges after the first write, assuming consecutive writes and rd_en held high.
- A simultaneous read and write to the same address cannot occur when level > 0. At level 0 the read is rejected, so no read-during-write hazard exists.
- If reset is asserted mid-operation, all outputs return to their reset values immediately (asynchronously). The FSM returns to FILL.

## Configuration
- RX_BUF_OVF_STICKY_EN defined: overflow is sticky. It sets on the first dropped write and clears only on flush or reset.
- RX_BUF_OVF_STICKY_EN undefined: overflow is a registered one-cycle pulse, high on the cycle after each dropped write.

## Test plan
All scenarios use AD=4, DATA=12, CH=2, START_LVL=4.
- Arm and drain:
  - Stimulus: write 0x001001..0x004004, with rd_en held high throughout.
  - Required: streaming=1 two edges after the 4th write; valid_out pulses 4 times with data in write order; underrun pulses once when empty; FSM returns to FILL.
- Full/overflow:
  - Stimulus: write 17 words with no reads.
  - Required: full=1 and level=16 after the 16th write; the 17th word is dropped; overflow=1 (sticky) or a single pulse (non-sticky); then reading 16 words returns words 1..16.
- Wrap-around:
  - Stimulus: 40 words written and read at a steady rate, keeping level between 4 and 10.
  - Required: output sequence equals input sequence; no overflow, no underrun.
- Simultaneous read and write:
  - Stimulus: at level=16, we and rd_en are asserted together.
  - Required: the write is dropped, the read is accepted, level=15.
  - Stimulus: at level=5 in STREAM, we and rd_en are asserted together.
  - Required: level stays 5.
- Flush and reset mid-stream:
  - Stimulus: flush asserted at level=7 with rd_en high.
  - Required: next cycle level=0, valid_out=0, streaming=0, overflow=0.
  - Stimulus: reset asserted between edges.
  - Required: all outputs go to their reset values immediately.

Source files
------------

// File: rtl/rx_sample_buffer_if.sv
// Sample buffer bus: write side, read side, flush and status.
// master = the block driving samples/requests, slave = rx_sample_buffer.
interface rx_sample_buffer_if #(
    parameter int AD   = 4,
    parameter int DATA = 12,
    parameter int CH   = 2
);
    localparam int W = CH * DATA;

    logic          flush;
    logic          we;
    logic [W-1:0]  data_in;
    logic          rd_en;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic [AD:0]   level;
    logic          full;
    logic          empty;
    logic          streaming;
    logic          overflow;
    logic          underrun;

    modport master (
        output flush, we, data_in, rd_en,
        input  data_out, valid_out, level, full, empty, streaming, overflow, underrun
    );

    modport slave (
        input  flush, we, data_in, rd_en,
        output data_out, valid_out, level, full, empty, streaming, overflow, underrun
    );
endinterface

// File: rtl/rx_sample_buffer.sv
// rx_sample_buffer: circular multi-channel sample store between the ADC
// front-end and the RX baseband chain. Reads are withheld (FILL) until the
// fill level reaches START_LVL, then streamed (STREAM) until a read finds
// the buffer empty.
// Optional feature macro: RX_BUF_OVF_STICKY_EN -- overflow stays high from
// the first dropped write until flush/reset; otherwise it is a one-cycle
// pulse following each dropped write.
module rx_sample_buffer #(
    parameter int AD        = 4,
    parameter int DATA      = 12,
    parameter int CH        = 2,
    parameter int START_LVL = 8
) (
    input  logic                clk,
    input  logic                reset,
    rx_sample_buffer_if.slave   bus
);
    localparam int W     = CH * DATA;
    localparam int DEPTH = 2 ** AD;

    localparam logic [AD:0] LVL_START = (AD + 1)'(START_LVL);
    localparam logic [AD:0] LVL_FULL  = (AD + 1)'(DEPTH);
    localparam logic [AD:0] LVL_ONE   = (AD + 1)'(1);
    localparam logic [AD:0] LVL_ZERO  = '0;

    typedef enum logic {FILL, STREAM} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    mem [DEPTH];
    logic [AD-1:0]   wr_ptr, rd_ptr;
    logic [AD:0]     level, level_nxt;
    logic            full_q, empty_q;
    logic            wr_acc, wr_drop, rd_acc, under_evt;
    logic [W-1:0]    data_q;
    logic            valid_q, ovf_q, und_q;

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.level     = level;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.streaming = (state == STREAM);
    assign bus.overflow  = ovf_q;
    assign bus.underrun  = und_q;

    // Accept/drop decisions use the registered full/empty, so a write at
    // full is dropped even when a read frees a slot on the same edge.
    always_comb begin
        wr_acc    = bus.we && !full_q && !bus.flush;
        wr_drop   = bus.we &&  full_q && !bus.flush;
        rd_acc    = bus.rd_en && (state == STREAM) && !empty_q && !bus.flush;
        under_evt = bus.rd_en && (state == STREAM) &&  empty_q && !bus.flush;
        level_nxt = level;
        if (bus.flush)
            level_nxt = LVL_ZERO;
        else if (wr_acc && !rd_acc)
            level_nxt = level + LVL_ONE;
        else if (rd_acc && !wr_acc)
            level_nxt = level - LVL_ONE;
    end

    // FSM next state: arm on registered level, fall back to FILL on an
    // empty read; a level dip below START_LVL does not disarm.
    always_comb begin
        state_nxt = state;
        if (bus.flush)
            state_nxt = FILL;
        else begin
            case (state)
                FILL:    if (level >= LVL_START)        state_nxt = STREAM;
                STREAM:  if (bus.rd_en && empty_q)      state_nxt = FILL;
                default:                                state_nxt = FILL;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    // Level and full/empty flags, registered from the next level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            level   <= level_nxt;
            full_q  <= (level_nxt == LVL_FULL);
            empty_q <= (level_nxt == LVL_ZERO);
        end
    end

    // Circular pointers; they wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sample RAM write port; contents survive flush and reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    // Registered read port: one-cycle latency, data holds when not valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) data_q <= mem[rd_ptr];
        end
    end

    // Overflow flag: sticky or per-drop pulse depending on build.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (bus.flush)
            ovf_q <= 1'b0;
`ifdef RX_BUF_OVF_STICKY_EN
        else if (wr_drop)
            ovf_q <= 1'b1;
`else
        else
            ovf_q <= wr_drop;
`endif
    end

    // Underrun pulse, coincident with the STREAM->FILL fallback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) und_q <= 1'b0;
        else       und_q <= under_evt;
    end
endmodule
